mem_dump_reader: RTL and testbench
==================================

# mem_dump_reader

Post-run data-memory reader for the single-cycle CPU. When the core raises `done`, the block takes over a read port of data memory and walks a fixed address window. It streams each byte out over a valid/ready byte interface to the testbench or host, so the CPU's written results can be extracted without hierarchical peeking. It is the read-side counterpart to the core's store path and sits beside `data_mem` at top level.

## Interface
Parameters:
- `ADDR_W`, 8: data-memory address width.
- `DATA_W`, 8: data-memory word width.
- `BASE`, 0: first address dumped.
- `COUNT`, 256: number of words dumped; legal range 1..2^ADDR_W.

Ports:
- `clk`  in  1: single clock. Everything is synchronous to its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `done`  in  1: CPU halt flag, level-sensitive; starts the dump.
- `mem_addr`  out  ADDR_W: read address to data memory (registered).
- `mem_rdata`  in  DATA_W: combinational read data for `mem_addr`.
- `out_valid`  out  1: output byte valid.
- `out_ready`  in  1: consumer accepts the byte.
- `out_data`  out  DATA_W: streamed byte.
- `out_last`  out  1: marks the final beat of the dump.
- `busy`  out  1: high from dump start until the last beat is accepted.
- `finished`  out  1: high once the dump completes; held until re-arm.

## Operation
- FSM states:
  - IDLE: wait for `done`=1, then load `ptr`=BASE and `left`=COUNT, and go to READ.
  - READ: `mem_addr`=`ptr`. On the clock edge, capture `mem_rdata` into `out_data`, set `out_valid`, and go to SEND.
  - SEND: hold `out_valid`. On `out_valid & out_ready`:
    - `ptr`++ (mod 2^ADDR_W), `left`--.
    - If `left` was 1, go to CSUM when the macro is defined, otherwise to FIN.
    - Otherwise go to READ.
  - CSUM (only when the macro is defined): present the checksum with `out_last`=1 and hold it until accepted, then go to FIN.
  - FIN: `finished`=1. Stay here while `done`=1. When `done`=0, return to IDLE (re-arm).
- `out_last` is 1 only on the final beat: the last data byte when the macro is not defined, the checksum beat when it is.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` are held stable.
- A drop of `done` during READ, SEND or CSUM is ignored, and the dump runs to completion.
- Address wrap: if BASE+COUNT exceeds 2^ADDR_W, `ptr` wraps to 0 and continues.
- The block never writes memory.

## Timing
- Reset values: `mem_addr`=BASE, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `finished`=0; state is IDLE.
- Reset in any state aborts the dump within the same edge, with no partial beat held afterwards.
- Start latency: if `done` is first sampled high at edge N (in IDLE), READ is entered at N+1 and `out_valid` rises after edge N+2.
- Throughput: 1 byte per 2 cycles with `out_ready` held at 1. Each back-pressure cycle adds 1 cycle.
- `busy` rises together with entry to READ and falls in the same edge as `finished` rises.
- The data byte for address A equals `mem_rdata` sampled while `mem_addr`=A in READ.

## Configuration
- `DUMP_CHECKSUM_EN`
  - Defined: CSUM state present. An 8-bit running sum of all dumped bytes (mod 256, cleared at start) is sent as one extra final beat, so a dump has COUNT+1 beats.
  - Undefined: no accumulator and no CSUM state; a dump has COUNT beats and the last data byte carries `out_last`.

## Structure
- The shared package `cpu_pkg` holds:
  - the `dump_state_t` enum (IDLE, READ, SEND, CSUM, FIN);
  - the default width constants `DMEM_ADDR_W`=8 and `DMEM_DATA_W`=8.
- The block is flat, with no sub-module; the FSM and counters are small.
- Top-level instantiation muxes `mem_addr` into the `data_mem` address input only while `busy`=1.

## Test plan
- Basic dump: memory preloaded with mem[i]=i, BASE=0, COUNT=4, `out_ready`=1. Raise `done` → bytes 0,1,2,3 on 4 accepted beats, `out_last` on byte 3, then `finished`=1.
- Back-pressure: hold `out_ready`=0 for 5 cycles on beat 2 → `out_data`=2 stays stable and `valid` stays high, with no skip or duplicate.
- Wrap: BASE=254, COUNT=4 → addresses 254,255,0,1 appear in order on `mem_addr`.
- Checksum (`DUMP_CHECKSUM_EN` defined): bytes 0x80,0x90,0x10 → 4th beat 0x20 with `out_last`=1.
- Reset mid-dump: assert `reset` during SEND of beat 1 → next cycle `out_valid`=0, `busy`=0, state IDLE. With `done` still high, a fresh dump restarts from BASE.
- Re-arm: in FIN, drop `done` and raise it again → a second full dump runs. Holding `done` high in FIN produces no second dump.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: dump-reader FSM states, default data-memory widths and
// the running-checksum helper.
package cpu_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    SEND = 3'd2,
    CSUM = 3'd3,
    FIN  = 3'd4
  } dump_state_t;

  // Modulo-256 accumulate of one dumped byte
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/mem_dump_reader.sv
// Post-run data-memory dump reader: walks COUNT words from BASE and streams them
// over a valid/ready byte port. Optional trailing checksum beat: DUMP_CHECKSUM_EN.
module mem_dump_reader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int BASE   = 0,
  parameter int COUNT  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              finished
);

  localparam int CNT_W = ADDR_W + 1;

  dump_state_t       state_r, state_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [CNT_W-1:0]  left_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r, out_last_r, busy_r, finished_r;
  logic              done_r;
  logic              load_s, capture_s, accept_s, last_s, rearm_s;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]        csum_r;
  logic              csum_accept_s;
`endif

  // Next-state and datapath strobes
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    capture_s = 1'b0;
    accept_s  = 1'b0;
    rearm_s   = 1'b0;
    last_s    = (left_r == CNT_W'(1));
`ifdef DUMP_CHECKSUM_EN
    csum_accept_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (done_r) begin
          state_s = READ;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        state_s   = SEND;
        capture_s = 1'b1;
      end
      SEND: begin
        if (out_valid_r && out_ready) begin
          accept_s = 1'b1;
          if (last_s) begin
`ifdef DUMP_CHECKSUM_EN
            state_s = CSUM;
`else
            state_s = FIN;
`endif
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = SEND;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM: begin
        if (out_ready) begin
          state_s       = FIN;
          csum_accept_s = 1'b1;
        end else begin
          state_s = CSUM;
        end
      end
`endif
      FIN: begin
        // Re-arm only after the CPU drops its halt flag
        if (!done_r) begin
          state_s = IDLE;
          rearm_s = 1'b1;
        end else begin
          state_s = FIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, pointer/counter and registered stream outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      done_r      <= 1'b0;
      ptr_r       <= ADDR_W'(BASE);
      left_r      <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      finished_r  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      state_r <= state_s;
      done_r  <= done;
      if (load_s) begin
        ptr_r  <= ADDR_W'(BASE);
        left_r <= CNT_W'(COUNT);
        busy_r <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
        csum_r <= 8'd0;
`endif
      end
      if (capture_s) begin
        out_data_r  <= mem_rdata;
        out_valid_r <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
        out_last_r  <= 1'b0;
        csum_r      <= csum_add(csum_r, 8'(mem_rdata));
`else
        out_last_r  <= last_s;
`endif
      end
      if (accept_s) begin
        ptr_r  <= ptr_r + ADDR_W'(1);
        left_r <= left_r - CNT_W'(1);
`ifdef DUMP_CHECKSUM_EN
        if (last_s) begin
          // Valid stays high: the checksum beat follows with no gap
          out_data_r <= DATA_W'(csum_r);
          out_last_r <= 1'b1;
        end else begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
`else
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
        if (last_s) begin
          busy_r     <= 1'b0;
          finished_r <= 1'b1;
        end
`endif
      end
`ifdef DUMP_CHECKSUM_EN
      if (csum_accept_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
        busy_r      <= 1'b0;
        finished_r  <= 1'b1;
      end
`endif
      if (rearm_s) begin
        finished_r <= 1'b0;
      end
    end
  end

  assign mem_addr  = ptr_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign finished  = finished_r;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: basic dump, back-pressure, wrap,
// checksum beat (DUMP_CHECKSUM_EN), reset mid-dump and re-arm.
module tb_mem_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       done0 = 1'b0, done1 = 1'b0;
  logic       ready0 = 1'b1, ready1 = 1'b1;
  logic [7:0] mem0 [256];
  logic [7:0] addr0, rdata0, data0, addr1, rdata1, data1;
  logic       valid0, last0, busy0, fin0, valid1, last1, busy1, fin1;

  assign rdata0 = mem0[addr0];
  assign rdata1 = addr1;

  mem_dump_reader #(.ADDR_W(8), .DATA_W(8), .BASE(0), .COUNT(4)) u0 (
    .clk(clk), .reset(reset), .done(done0), .mem_addr(addr0), .mem_rdata(rdata0),
    .out_valid(valid0), .out_ready(ready0), .out_data(data0), .out_last(last0),
    .busy(busy0), .finished(fin0));

  mem_dump_reader #(.ADDR_W(8), .DATA_W(8), .BASE(254), .COUNT(4)) u1 (
    .clk(clk), .reset(reset), .done(done1), .mem_addr(addr1), .mem_rdata(rdata1),
    .out_valid(valid1), .out_ready(ready1), .out_data(data1), .out_last(last1),
    .busy(busy1), .finished(fin1));

  typedef struct { logic [7:0] d; logic l; logic [7:0] a; } beat_t;
  beat_t q0[$];
  beat_t q1[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input logic ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push0(input logic [7:0] b0, b1, b2, b3, input logic [7:0] cs);
    logic [7:0] bs [4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int i = 0; i < 4; i++) begin
`ifdef DUMP_CHECKSUM_EN
      q0.push_back('{bs[i], 1'b0, 8'd0});
`else
      q0.push_back('{bs[i], (i == 3), 8'd0});
`endif
    end
`ifdef DUMP_CHECKSUM_EN
    q0.push_back('{cs, 1'b1, 8'd0});
`endif
  endtask

  // Monitor for u0: stability under back-pressure and scoreboard pop on handshake
  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;
  always @(negedge clk) begin
    beat_t b;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk(valid0 == 1'b1, "bp_valid_held", int'(valid0), 1);
        chk(data0 == hold_d, "bp_data_stable", int'(data0), int'(hold_d));
        chk(last0 == hold_l, "bp_last_stable", int'(last0), int'(hold_l));
      end
      hold_v = valid0 && !ready0;
      hold_d = data0;
      hold_l = last0;
      if (valid0 && ready0) begin
        if (q0.size() == 0) begin
          chk(1'b0, "u0_unexpected_beat", int'(data0), -1);
        end else begin
          b = q0.pop_front();
          chk(data0 == b.d, "u0_beat_data", int'(data0), int'(b.d));
          chk(last0 == b.l, "u0_beat_last", int'(last0), int'(b.l));
        end
      end
    end
  end

  // Monitor for u1: wrapping window, checks address alongside data
  always @(negedge clk) begin
    beat_t b;
    if (!reset && valid1 && ready1) begin
      if (q1.size() == 0) begin
        chk(1'b0, "u1_unexpected_beat", int'(data1), -1);
      end else begin
        b = q1.pop_front();
        chk(data1 == b.d, "u1_beat_data", int'(data1), int'(b.d));
        chk(last1 == b.l, "u1_beat_last", int'(last1), int'(b.l));
        chk(addr1 == b.a, "u1_mem_addr", int'(addr1), int'(b.a));
      end
    end
  end

  // Run u0 until finished; optionally stall 5 cycles on the beat carrying bp_val
  task automatic run0(input int bp_val, input string tag, output int cycles);
    int  bp = 0;
    bit  bp_used = 1'b0;
    cycles = 0;
    while (!fin0 && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      if (bp > 0) begin
        bp--;
        if (bp == 0) ready0 = 1'b1;
      end else if (!bp_used && bp_val >= 0 && valid0 && int'(data0) == bp_val) begin
        ready0  = 1'b0;
        bp      = 5;
        bp_used = 1'b1;
      end
    end
    chk(fin0 == 1'b1, {tag, "_finished"}, int'(fin0), 1);
    chk(busy0 == 1'b0, {tag, "_busy_low"}, int'(busy0), 0);
  endtask

  initial begin
    int cyc;
    int vcount;
    for (int i = 0; i < 256; i++) mem0[i] = 8'(i);

    repeat (2) @(posedge clk);
    #1;
    chk(addr0 == 8'd0, "rst_mem_addr0", int'(addr0), 0);
    chk(addr1 == 8'd254, "rst_mem_addr1", int'(addr1), 254);
    chk(valid0 == 1'b0, "rst_valid", int'(valid0), 0);
    chk(data0 == 8'd0, "rst_data", int'(data0), 0);
    chk(last0 == 1'b0, "rst_last", int'(last0), 0);
    chk(busy0 == 1'b0, "rst_busy", int'(busy0), 0);
    chk(fin0 == 1'b0, "rst_finished", int'(fin0), 0);
    reset = 1'b0;

    // Basic dump with back-pressure on byte 2, plus wrapping dump on u1
    push0(8'd0, 8'd1, 8'd2, 8'd3, 8'd6);
    q1.push_back('{8'd254, 1'b0, 8'd254});
    q1.push_back('{8'd255, 1'b0, 8'd255});
    q1.push_back('{8'd0, 1'b0, 8'd0});
`ifdef DUMP_CHECKSUM_EN
    q1.push_back('{8'd1, 1'b0, 8'd1});
    q1.push_back('{8'd254, 1'b1, 8'd2});
`else
    q1.push_back('{8'd1, 1'b1, 8'd1});
`endif
    @(posedge clk); #1;
    done0 = 1'b1;
    done1 = 1'b1;
    @(posedge clk); #1;
    chk(busy0 == 1'b0, "lat_busy_edge1", int'(busy0), 0);
    @(posedge clk); #1;
    chk(busy0 == 1'b1, "lat_busy_edge2", int'(busy0), 1);
    chk(valid0 == 1'b0, "lat_valid_edge2", int'(valid0), 0);
    @(posedge clk); #1;
    chk(valid0 == 1'b1, "lat_valid_edge3", int'(valid0), 1);
    run0(2, "dump1", cyc);
    chk(fin1 == 1'b1, "wrap_finished", int'(fin1), 1);

    // Holding done high in FIN must not start another dump
    vcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid0) vcount++;
    end
    chk(vcount == 0, "hold_done_no_redump", vcount, 0);
    chk(fin0 == 1'b1, "hold_done_finished", int'(fin0), 1);

    // Re-arm with checksum pattern, also timing the unstalled dump
    done0 = 1'b0;
    done1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(fin0 == 1'b0, "rearm_finished_clear", int'(fin0), 0);
    mem0[0] = 8'h80; mem0[1] = 8'h90; mem0[2] = 8'h10; mem0[3] = 8'h00;
    push0(8'h80, 8'h90, 8'h10, 8'h00, 8'h20);
    done0 = 1'b1;
    run0(-1, "dump2", cyc);
`ifdef DUMP_CHECKSUM_EN
    chk(cyc == 11, "dump2_cycles", cyc, 11);
`else
    chk(cyc == 10, "dump2_cycles", cyc, 10);
`endif

    // Reset during SEND of the first beat, then restart with done still high
    done0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready0 = 1'b0;
    done0  = 1'b1;
    cyc = 0;
    while (!valid0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(valid0 == 1'b1, "mid_reset_reached_send", int'(valid0), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk(valid0 == 1'b0, "mid_reset_valid", int'(valid0), 0);
    chk(busy0 == 1'b0, "mid_reset_busy", int'(busy0), 0);
    chk(last0 == 1'b0, "mid_reset_last", int'(last0), 0);
    chk(addr0 == 8'd0, "mid_reset_addr", int'(addr0), 0);
    reset  = 1'b0;
    ready0 = 1'b1;
    push0(8'h80, 8'h90, 8'h10, 8'h00, 8'h20);
    run0(-1, "dump3", cyc);

    repeat (2) @(posedge clk);
    chk(q0.size() == 0, "u0_queue_drained", q0.size(), 0);
    chk(q1.size() == 0, "u1_queue_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
